qam_tx_gen: RTL and testbench

QAM_TX_GEN -- requirements
Module: qam_tx_gen

---
 rtl/qam_tx_gen.sv | 174 +++++++++++++++++
 tb/tb_qam_tx_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_tx_gen.sv
// -----------------------------------------------------------------------------
// qam_tx_gen
//   PRBS-7 driven QPSK / 16-QAM symbol generator with zero-stuffed upsampling
//   and a valid/ready output handshake.
//
//   Each symbol takes 2 (QPSK) or 4 (16-QAM) PRBS bits in one cycle and is
//   presented for OSR beats: the symbol value on beat 0, zeros on the rest.
//   The PRBS state survives IDLE; only reset reloads SEED.
//
//   Optional feature macro: QAM_TX_GRAY_EN
//     undefined : natural 16-QAM pair mapping 00->-3 01->-1 10->+1 11->+3
//     defined   : Gray    16-QAM pair mapping 00->-3 01->-1 11->+1 10->+3
//
// Parameters
//   OSR   : output beats per symbol (2..16)
//   OUT_W : signed I/Q output width (>= 3)
//   SEED  : PRBS-7 reset state (0 is replaced by 7'h7F)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   en         in   start / continue symbol generation
//   mode       in   0 = QPSK, 1 = 16-QAM (sampled when a symbol is loaded)
//   out_ready  in   sink accepts the current beat
//   out_valid  out  dout_i/dout_q carry a valid beat
//   dout_i     out  signed I sample
//   dout_q     out  signed Q sample
//   sym_strobe out  current beat is phase 0 of a symbol
// -----------------------------------------------------------------------------
module qam_tx_gen #(
   parameter int unsigned OSR   = 4,
   parameter int unsigned OUT_W = 4,
   parameter logic [6:0]  SEED  = 7'h7F
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] dout_i,
   output logic signed [OUT_W-1:0] dout_q,
   output logic                    sym_strobe
);

   localparam int unsigned     PH_W     = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
   localparam logic [6:0]      SEED_EFF = (SEED == 7'd0) ? 7'h7F : SEED;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic [6:0]              prbs_q, prbs_d;
   logic signed [OUT_W-1:0] di_q, di_d;
   logic signed [OUT_W-1:0] dq_q, dq_d;

   // Candidate symbol built from the current PRBS state
   logic [6:0]              s1, s2, s3, s4;
   logic                    b0, b1, b2, b3;
   logic signed [OUT_W-1:0] sym_i, sym_q;
   logic [6:0]              prbs_after;
   logic                    xfer;

   // x^7 + x^6 + 1: emitted bit is s[6], feedback s[6]^s[5] enters at s[0]
   function automatic logic [6:0] prbs_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   function automatic logic signed [OUT_W-1:0] map_bit(input logic b);
      logic signed [2:0] lv;
      lv = b ? 3'sb001 : 3'sb111;
      return OUT_W'(lv);
   endfunction

   // First bit of the pair is the MSB
   function automatic logic signed [OUT_W-1:0] map_pair(input logic msb, input logic lsb);
      logic signed [2:0] lv;
      case ({msb, lsb})
`ifdef QAM_TX_GRAY_EN
         2'b00:   lv = 3'sb101;
         2'b01:   lv = 3'sb111;
         2'b11:   lv = 3'sb001;
         default: lv = 3'sb011;
`else
         2'b00:   lv = 3'sb101;
         2'b01:   lv = 3'sb111;
         2'b10:   lv = 3'sb001;
         default: lv = 3'sb011;
`endif
      endcase
      return OUT_W'(lv);
   endfunction

   always_comb begin
      s1 = prbs_step(prbs_q);
      s2 = prbs_step(s1);
      s3 = prbs_step(s2);
      s4 = prbs_step(s3);
      b0 = prbs_q[6];
      b1 = s1[6];
      b2 = s2[6];
      b3 = s3[6];
      if (mode) begin
         sym_i      = map_pair(b0, b1);
         sym_q      = map_pair(b2, b3);
         prbs_after = s4;
      end else begin
         sym_i      = map_bit(b0);
         sym_q      = map_bit(b1);
         prbs_after = s2;
      end
   end

   assign xfer = (state_q == RUN) && out_ready;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      prbs_d  = prbs_q;
      di_d    = di_q;
      dq_d    = dq_q;
      if (state_q == IDLE) begin
         if (en) begin
            state_d = RUN;
            phase_d = '0;
            prbs_d  = prbs_after;
            di_d    = sym_i;
            dq_d    = sym_q;
         end
      end else if (xfer) begin
         if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (en) begin
               // Next symbol follows the last beat with no bubble
               prbs_d = prbs_after;
               di_d   = sym_i;
               dq_d   = sym_q;
            end else begin
               state_d = IDLE;
               di_d    = '0;
               dq_d    = '0;
            end
         end else begin
            // Zero-stuffing for phases 1..OSR-1
            phase_d = phase_q + PH_W'(1);
            di_d    = '0;
            dq_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         phase_q <= '0;
         prbs_q  <= SEED_EFF;
         di_q    <= '0;
         dq_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         prbs_q  <= prbs_d;
         di_q    <= di_d;
         dq_q    <= dq_d;
      end
   end

   assign out_valid  = (state_q == RUN);
   assign sym_strobe = out_valid && (phase_q == '0);
   assign dout_i     = di_q;
   assign dout_q     = dq_q;

endmodule

// File: tb/tb_qam_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_qam_tx_gen
//   Directed self-checking bench for qam_tx_gen (OSR=4, OUT_W=4, SEED=7'h7F).
//   PRBS bits from SEED 7'h7F: b0..b6 = 1, b7..b12 = 0, b13 = 1, b14..b18 = 0,
//   b19 = 1.
// -----------------------------------------------------------------------------
module tb_qam_tx_gen;

   logic              clk;
   logic              reset;
   logic              en;
   logic              mode;
   logic              out_ready;
   logic              out_valid;
   logic signed [3:0] dout_i;
   logic signed [3:0] dout_q;
   logic              sym_strobe;

   int checks = 0;
   int errors = 0;

`ifdef QAM_TX_GRAY_EN
   localparam logic signed [3:0] S1I = 4'sd1, S1Q = 4'sd1, S2I = 4'sd1, S2Q = 4'sd3;
`else
   localparam logic signed [3:0] S1I = 4'sd3, S1Q = 4'sd3, S2I = 4'sd3, S2Q = 4'sd1;
`endif

   qam_tx_gen #(.OSR(4), .OUT_W(4), .SEED(7'h7F)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .dout_i     (dout_i),
      .dout_q     (dout_q),
      .sym_strobe (sym_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset     = 1'b0;
      en        = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || sym_strobe !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: valid=%b strobe=%b i=%0d q=%0d, required 0 0 0 0",
                     c, out_valid, sym_strobe, dout_i, dout_q);
         end
      end
   endtask

   task automatic test_qam16();
      logic signed [3:0] ei [3];
      logic signed [3:0] eq [3];
      logic signed [3:0] xi, xq;
      ei = '{S1I, S2I, -4'sd3};
      eq = '{S1Q, S2Q, -4'sd3};
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      for (int s = 0; s < 3; s++) begin
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            xi = (b == 0) ? ei[s] : 4'sd0;
            xq = (b == 0) ? eq[s] : 4'sd0;
            checks++;
            if (out_valid !== 1'b1 || sym_strobe !== (b == 0) || dout_i !== xi || dout_q !== xq) begin
               errors++;
               $display("FAIL qam16 sym%0d beat%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 %b %0d %0d",
                        s, b, out_valid, sym_strobe, dout_i, dout_q, (b == 0), xi, xq);
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_qpsk();
      logic signed [3:0] ei [4];
      logic signed [3:0] eq [4];
      logic signed [3:0] xi, xq;
      ei = '{4'sd1, 4'sd1, 4'sd1, 4'sd1};
      eq = '{4'sd1, 4'sd1, 4'sd1, -4'sd1};
      do_reset();
      mode = 1'b0;
      en   = 1'b1;
      for (int s = 0; s < 4; s++) begin
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            xi = (b == 0) ? ei[s] : 4'sd0;
            xq = (b == 0) ? eq[s] : 4'sd0;
            checks++;
            if (out_valid !== 1'b1 || sym_strobe !== (b == 0) || dout_i !== xi || dout_q !== xq) begin
               errors++;
               $display("FAIL qpsk sym%0d beat%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 %b %0d %0d",
                        s, b, out_valid, sym_strobe, dout_i, dout_q, (b == 0), xi, xq);
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_stall();
      logic signed [3:0] ei [5];
      logic signed [3:0] eq [5];
      logic signed [3:0] xi, xq;
      ei = '{S1I, S2I, -4'sd3, -4'sd1, -4'sd3};
      eq = '{S1Q, S2Q, -4'sd3, -4'sd3, -4'sd1};
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      for (int s = 0; s < 5; s++) begin
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            xi = (b == 0) ? ei[s] : 4'sd0;
            xq = (b == 0) ? eq[s] : 4'sd0;
            checks++;
            if (out_valid !== 1'b1 || sym_strobe !== (b == 0) || dout_i !== xi || dout_q !== xq) begin
               errors++;
               $display("FAIL stall_seq sym%0d beat%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 %b %0d %0d",
                        s, b, out_valid, sym_strobe, dout_i, dout_q, (b == 0), xi, xq);
            end
            if ((s == 0 && b == 2) || (s == 1 && b == 0)) begin
               out_ready = 1'b0;
               for (int c = 0; c < ((s == 0) ? 5 : 2); c++) begin
                  @(negedge clk);
                  checks++;
                  if (out_valid !== 1'b1 || sym_strobe !== (b == 0) || dout_i !== xi || dout_q !== xq) begin
                     errors++;
                     $display("FAIL stall_hold sym%0d beat%0d cyc%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 %b %0d %0d",
                              s, b, c, out_valid, sym_strobe, dout_i, dout_q, (b == 0), xi, xq);
                  end
               end
               out_ready = 1'b1;
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_en_drop();
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== 1'b1 || dout_i !== S1I || dout_q !== S1Q) begin
         errors++;
         $display("FAIL endrop_first: valid=%b strobe=%b i=%0d q=%0d, required 1 1 %0d %0d",
                  out_valid, sym_strobe, dout_i, dout_q, S1I, S1Q);
      end
      @(negedge clk);
      en = 1'b0;
      for (int b = 2; b < 4; b++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || sym_strobe !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
            errors++;
            $display("FAIL endrop_tail beat%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 0 0 0",
                     b, out_valid, sym_strobe, dout_i, dout_q);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || sym_strobe !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
            errors++;
            $display("FAIL endrop_idle cyc%0d: valid=%b strobe=%b i=%0d q=%0d, required 0 0 0 0",
                     c, out_valid, sym_strobe, dout_i, dout_q);
         end
      end
      en = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== 1'b1 || dout_i !== S2I || dout_q !== S2Q) begin
         errors++;
         $display("FAIL endrop_resume: valid=%b strobe=%b i=%0d q=%0d, required 1 1 %0d %0d",
                  out_valid, sym_strobe, dout_i, dout_q, S2I, S2Q);
      end
      en = 1'b0;
   endtask

   task automatic test_mode_change();
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      @(negedge clk);
      mode = 1'b0;
      for (int b = 1; b < 4; b++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || sym_strobe !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
            errors++;
            $display("FAIL modechg_tail beat%0d: valid=%b strobe=%b i=%0d q=%0d, required 1 0 0 0",
                     b, out_valid, sym_strobe, dout_i, dout_q);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== 1'b1 || dout_i !== 4'sd1 || dout_q !== 4'sd1) begin
         errors++;
         $display("FAIL modechg_next: valid=%b strobe=%b i=%0d q=%0d, required 1 1 1 1",
                  out_valid, sym_strobe, dout_i, dout_q);
      end
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sym_strobe !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
         errors++;
         $display("FAIL rstmid_async: valid=%b strobe=%b i=%0d q=%0d, required 0 0 0 0",
                  out_valid, sym_strobe, dout_i, dout_q);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || dout_i !== 4'sd0 || dout_q !== 4'sd0) begin
         errors++;
         $display("FAIL rstmid_held: valid=%b i=%0d q=%0d, required 0 0 0",
                  out_valid, dout_i, dout_q);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sym_strobe !== 1'b1 || dout_i !== S1I || dout_q !== S1Q) begin
         errors++;
         $display("FAIL rstmid_restart: valid=%b strobe=%b i=%0d q=%0d, required 1 1 %0d %0d",
                  out_valid, sym_strobe, dout_i, dout_q, S1I, S1Q);
      end
      en = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      en        = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_qam16();
      test_qpsk();
      test_stall();
      test_en_drop();
      test_mode_change();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
